// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_pkg;

    localparam logic [4:0] REG_ZERO = 5'd31;   // hard-wired zero register, writes are dropped
    localparam int         XLEN     = 64;
    localparam int         NREG     = 32;

    // One buffered LSU result: destination register and data.
    typedef struct packed {
        logic [4:0]      rw;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Bundle of ALU/LSU result inputs, register-file write port, Pending and Count.
// Latency: n/a (wires only).
// Backpressure: LsuValid/LsuReady handshake on the LSU side; the ALU side has none.
// master = upstream/issue side that drives results, slave = the arbiter.
interface writeback_arbiter_if #(
    parameter int CW = 3
);
    import wb_pkg::*;

    logic                AluWr;
    logic [4:0]          AluRW;
    logic [XLEN-1:0]     AluData;
    logic                LsuValid;
    logic [4:0]          LsuRW;
    logic [XLEN-1:0]     LsuData;
    logic                LsuReady;
    logic                RegWr;
    logic [4:0]          RW;
    logic [XLEN-1:0]     BusW;
    logic [NREG-1:0]     Pending;
    logic [CW-1:0]       Count;

    modport master (
        output AluWr, AluRW, AluData, LsuValid, LsuRW, LsuData,
        input  LsuReady, RegWr, RW, BusW, Pending, Count
    );

    modport slave (
        input  AluWr, AluRW, AluData, LsuValid, LsuRW, LsuData,
        output LsuReady, RegWr, RW, BusW, Pending, Count
    );
endinterface

// File: rtl/wb_fifo.sv
// DEPTH-entry synchronous FIFO of wb_entry_t; exposes per-entry valid/rw for Pending.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: caller must not push when full nor pop when empty; full/empty are registered-state only.
// Ports: clk/rst_n, push/push_dat, pop/head_dat, full/empty/count, ent_vld/ent_rw.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  wb_entry_t             push_dat,
    input  logic                  pop,
    output wb_entry_t             head_dat,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count,
    output logic [DEPTH-1:0]      ent_vld,
    output logic [DEPTH-1:0][4:0] ent_rw
);
    localparam int AW = $clog2(DEPTH);

    wb_entry_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  cnt;
    logic [DEPTH-1:0] vld;

    // Storage needs no reset: every slot is qualified by vld.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    // A push and a pop in the same cycle never touch the same slot: pop needs
    // a non-empty FIFO and push needs a non-full one, so wr_ptr != rd_ptr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            vld    <= '0;
        end else begin
            if (push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_rw[i] = mem[i].rw;
        end
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign ent_vld  = vld;

endmodule

// File: rtl/writeback_arbiter.sv
// Sole driver of the register-file write port; merges ALU results with buffered/bypassed LSU results.
// Latency: slot winner in cycle t appears on RegWr/RW/BusW in cycle t+1.
// Backpressure: ALU never stalls and always wins; LsuReady = FIFO not full (state only, no LsuValid path).
// Ports: Clk, ResetL (sync, active-low), bus (slave modport: ALU/LSU inputs, write port, Pending, Count).
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic                Clk,
    input  logic                ResetL,
    writeback_arbiter_if.slave  bus
);
    wb_entry_t                fifo_head;
    wb_entry_t                lsu_ent;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CW-1:0]            fifo_count;
    logic [DEPTH-1:0]         ent_vld;
    logic [DEPTH-1:0][4:0]    ent_rw;

    logic                     lsu_rdy;
    logic                     alu_win;
    logic                     lsu_keep;
    logic                     pop;
    logic                     bypass;
    logic                     push;

    logic                     win;
    logic [4:0]               win_rw;
    logic [XLEN-1:0]          win_dat;

    logic                     reg_wr_q;
    logic [4:0]               rw_q;
    logic [XLEN-1:0]          busw_q;
    logic [NREG-1:0]          pend;

    // A write to the zero register is treated as if nothing were offered.
    assign alu_win  = bus.AluWr && (bus.AluRW != REG_ZERO);
    assign lsu_rdy  = !fifo_full;
    assign lsu_keep = bus.LsuValid && lsu_rdy && (bus.LsuRW != REG_ZERO);

    // ALU > FIFO head > direct LSU bypass. Bypass only when the FIFO is empty,
    // so LSU results always leave in acceptance order.
    assign pop    = !alu_win && !fifo_empty;
    assign bypass = !alu_win && fifo_empty && lsu_keep;
    assign push   = lsu_keep && !bypass;

    assign lsu_ent.rw   = bus.LsuRW;
    assign lsu_ent.data = bus.LsuData;

    wb_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk      (Clk),
        .rst_n    (ResetL),
        .push     (push),
        .push_dat (lsu_ent),
        .pop      (pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .ent_vld  (ent_vld),
        .ent_rw   (ent_rw)
    );

    always_comb begin
        win     = 1'b0;
        win_rw  = REG_ZERO;
        win_dat = '0;
        if (alu_win) begin
            win     = 1'b1;
            win_rw  = bus.AluRW;
            win_dat = bus.AluData;
        end else if (pop) begin
            win     = 1'b1;
            win_rw  = fifo_head.rw;
            win_dat = fifo_head.data;
        end else if (bypass) begin
            win     = 1'b1;
            win_rw  = bus.LsuRW;
            win_dat = bus.LsuData;
        end
    end

    // RW/BusW hold their last value on idle slots; only RegWr drops.
    always_ff @(posedge Clk) begin
        if (!ResetL) begin
            reg_wr_q <= 1'b0;
            rw_q     <= REG_ZERO;
            busw_q   <= '0;
        end else begin
            reg_wr_q <= win;
            if (win) begin
                rw_q   <= win_rw;
                busw_q <= win_dat;
            end
        end
    end

    // Pending comes straight from FIFO slot state, so an entry's bit drops in
    // the same cycle its data appears on the write port.
    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i]) begin
                pend[ent_rw[i]] = 1'b1;
            end
        end
        pend[REG_ZERO] = 1'b0;
    end

    assign bus.LsuReady = lsu_rdy;
    assign bus.RegWr    = reg_wr_q;
    assign bus.RW       = rw_q;
    assign bus.BusW     = busw_q;
    assign bus.Pending  = pend;
    assign bus.Count    = fifo_count;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: cycle-by-cycle vector table plus a FIFO-fill/drain sequence.
// Latency: n/a.
// Backpressure: LSU offers are held until LsuReady is seen.
module tb_writeback_arbiter;

    logic clk;
    logic rst_l;
    int   tests;
    int   fails;

    writeback_arbiter_if #(.CW(3)) bus ();

    writeback_arbiter #(
        .DEPTH (4),
        .CW    (3)
    ) dut (
        .Clk    (clk),
        .ResetL (rst_l),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_l;
        logic        aw;
        logic [4:0]  arw;
        logic [63:0] ad;
        logic        lv;
        logic [4:0]  lrw;
        logic [63:0] ld;
        logic        e_wr;
        logic [4:0]  e_rw;
        logic [63:0] e_bw;
        logic [2:0]  e_cnt;
        logic        e_rdy;
        logic [31:0] e_pend;
    } vec_t;

    localparam int NV = 23;
    vec_t vt [NV];

    function automatic vec_t mk(input logic r, input logic aw, input logic [4:0] arw,
                                input logic [63:0] ad, input logic lv, input logic [4:0] lrw,
                                input logic [63:0] ld, input logic e_wr, input logic [4:0] e_rw,
                                input logic [63:0] e_bw, input logic [2:0] e_cnt,
                                input logic e_rdy, input logic [31:0] e_pend);
        vec_t v;
        v.rst_l = r;   v.aw = aw;   v.arw = arw;   v.ad = ad;
        v.lv = lv;     v.lrw = lrw; v.ld = ld;
        v.e_wr = e_wr; v.e_rw = e_rw; v.e_bw = e_bw;
        v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_pend = e_pend;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Upstream must never issue an ALU write to a register with an outstanding load.
    task automatic check_obligation(input string name);
        logic viol;
        viol = bus.AluWr && (bus.AluRW != 5'd31) && bus.Pending[bus.AluRW];
        check(name, {63'd0, viol}, 64'd0);
    endtask

    task automatic drive(input logic aw, input logic [4:0] arw, input logic [63:0] ad,
                         input logic lv, input logic [4:0] lrw, input logic [63:0] ld);
        bus.AluWr    = aw;
        bus.AluRW    = arw;
        bus.AluData  = ad;
        bus.LsuValid = lv;
        bus.LsuRW    = lrw;
        bus.LsuData  = ld;
    endtask

    // Per-cycle history for the fill/drain sequence.
    logic        wr_hist [20];
    logic [4:0]  w_rw    [8];
    logic [63:0] w_dat   [8];
    int          w_cyc   [8];

    initial begin
        int k;
        int nw;
        logic hs;
        tests = 0;
        fails = 0;
        rst_l = 1'b0;
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);

        //          rst aw arw    ad        lv lrw    ld         wr rw     busw      cnt   rdy pend
        vt[0]  = mk(0, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,     0, 5'd31, 64'h0,    3'd0, 1, 32'h0);
        vt[1]  = mk(1, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,     0, 5'd31, 64'h0,    3'd0, 1, 32'h0);
        vt[2]  = mk(1, 1, 5'd5,  64'h1234, 0, 5'd0,  64'h0,     1, 5'd5,  64'h1234, 3'd0, 1, 32'h0);
        vt[3]  = mk(1, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,     0, 5'd5,  64'h1234, 3'd0, 1, 32'h0);
        vt[4]  = mk(1, 1, 5'd3,  64'hAA,   1, 5'd7,  64'hBB,    1, 5'd3,  64'hAA,   3'd1, 1, 32'h80);
        vt[5]  = mk(1, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,     1, 5'd7,  64'hBB,   3'd0, 1, 32'h0);
        vt[6]  = mk(1, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,     0, 5'd7,  64'hBB,   3'd0, 1, 32'h0);
        vt[7]  = mk(1, 0, 5'd0,  64'h0,    1, 5'd9,  64'h99,    1, 5'd9,  64'h99,   3'd0, 1, 32'h0);
        vt[8]  = mk(1, 0, 5'd0,  64'h0,    1, 5'd31, 64'h55,    0, 5'd9,  64'h99,   3'd0, 1, 32'h0);
        vt[9]  = mk(1, 1, 5'd4,  64'h44,   1, 5'd2,  64'h22,    1, 5'd4,  64'h44,   3'd1, 1, 32'h4);
        vt[10] = mk(1, 1, 5'd31, 64'h77,   0, 5'd0,  64'h0,     1, 5'd2,  64'h22,   3'd0, 1, 32'h0);
        vt[11] = mk(1, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,     0, 5'd2,  64'h22,   3'd0, 1, 32'h0);
        vt[12] = mk(1, 1, 5'd1,  64'h11,   1, 5'd10, 64'hA0,    1, 5'd1,  64'h11,   3'd1, 1, 32'h400);
        vt[13] = mk(1, 1, 5'd1,  64'h12,   1, 5'd11, 64'hA1,    1, 5'd1,  64'h12,   3'd2, 1, 32'hC00);
        vt[14] = mk(1, 1, 5'd1,  64'h13,   1, 5'd12, 64'hA2,    1, 5'd1,  64'h13,   3'd3, 1, 32'h1C00);
        vt[15] = mk(0, 1, 5'd1,  64'h14,   1, 5'd13, 64'hA3,    0, 5'd31, 64'h0,    3'd0, 1, 32'h0);
        vt[16] = mk(1, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,     0, 5'd31, 64'h0,    3'd0, 1, 32'h0);
        vt[17] = mk(1, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,     0, 5'd31, 64'h0,    3'd0, 1, 32'h0);
        vt[18] = mk(1, 1, 5'd6,  64'h66,   1, 5'd20, 64'hC0,    1, 5'd6,  64'h66,   3'd1, 1, 32'h100000);
        vt[19] = mk(1, 0, 5'd0,  64'h0,    1, 5'd21, 64'hC1,    1, 5'd20, 64'hC0,   3'd1, 1, 32'h200000);
        vt[20] = mk(1, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,     1, 5'd21, 64'hC1,   3'd0, 1, 32'h0);
        vt[21] = mk(1, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,     0, 5'd21, 64'hC1,   3'd0, 1, 32'h0);
        vt[22] = mk(1, 1, 5'd8,  64'h88,   1, 5'd31, 64'hFF,    1, 5'd8,  64'h88,   3'd0, 1, 32'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_l = vt[i].rst_l;
            drive(vt[i].aw, vt[i].arw, vt[i].ad, vt[i].lv, vt[i].lrw, vt[i].ld);
            if (vt[i].rst_l) check_obligation($sformatf("v%0d obligation", i));
            @(posedge clk);
            #1;
            check($sformatf("v%0d RegWr", i),    {63'd0, bus.RegWr},    {63'd0, vt[i].e_wr});
            check($sformatf("v%0d RW", i),       {59'd0, bus.RW},       {59'd0, vt[i].e_rw});
            check($sformatf("v%0d BusW", i),     bus.BusW,              vt[i].e_bw);
            check($sformatf("v%0d Count", i),    {61'd0, bus.Count},    {61'd0, vt[i].e_cnt});
            check($sformatf("v%0d LsuReady", i), {63'd0, bus.LsuReady}, {63'd0, vt[i].e_rdy});
            check($sformatf("v%0d Pending", i),  {32'd0, bus.Pending},  {32'd0, vt[i].e_pend});
        end

        // Fill to full behind a busy ALU, stall a fifth load, then drain in order.
        k  = 0;
        nw = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            drive(c < 6, 5'd1, 64'(c), k < 5, 5'(10 + k), 64'h100 + 64'(k));
            hs = bus.LsuValid && bus.LsuReady;
            check_obligation($sformatf("fill c%0d obligation", c));
            @(posedge clk);
            #1;
            if (hs) k++;
            if (c == 5) begin
                check("fill Count at full",    {61'd0, bus.Count},    64'd4);
                check("fill LsuReady at full", {63'd0, bus.LsuReady}, 64'd0);
                check("fill accepts at full",  64'(k),                64'd4);
                check("fill Pending at full",  {32'd0, bus.Pending},  64'h3C00);
            end
            if (c == 6) begin
                check("LsuReady same cycle as pop", {63'd0, bus.LsuReady}, 64'd1);
            end
            wr_hist[c] = bus.RegWr;
            if (bus.RegWr && bus.RW != 5'd1 && nw < 8) begin
                w_rw[nw]  = bus.RW;
                w_dat[nw] = bus.BusW;
                w_cyc[nw] = c;
                nw++;
            end
        end
        check("drain accepts", 64'(k), 64'd5);
        check("drain write count", 64'(nw), 64'd5);
        if (nw == 5) begin
            for (int j = 0; j < 5; j++) begin
                check($sformatf("drain%0d RW", j),    {59'd0, w_rw[j]}, 64'(10 + j));
                check($sformatf("drain%0d BusW", j),  w_dat[j],         64'h100 + 64'(j));
                check($sformatf("drain%0d cycle", j), 64'(w_cyc[j]),    64'(6 + j));
            end
        end
        check("drain idle after X14", {63'd0, wr_hist[11]}, 64'd0);
        check("drain final Count",    {61'd0, bus.Count},   64'd0);
        check("drain final Pending",  {32'd0, bus.Pending}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, expected completion before 100000");
        $fatal(1, "timeout");
    end

endmodule
